tnet_tx_queue: RTL

- Upstream feeder of the Aurora link controller's transmit path.
- Accepts tnet messages from the core-side command logic through a valid/ready port and buffers them in a small FIFO.
- Frames each message into the 128-bit tnet packet format and hands it to the link controller over a 4-phase req/ack handshake; the link controller re-synchronises req/data into its user clock domain.
- Also keeps per-packet sequence numbering, link-timeout detection and status counters.

---
 rtl/tnet_tx_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tnet_tx_queue.sv
// tnet transmit queue: buffers core messages, frames them into 128-bit
// packets and drives a 4-phase req/ack handshake toward the link controller.
module tnet_tx_queue #(
    parameter int DEPTH  = 4,
    parameter int TO_CYC = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [7:0]   ID,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [7:0]   in_op_i,
    input  logic [8:0]   in_dst_i,
    input  logic         in_sync_i,
    input  logic [95:0]  in_dt_i,
    output logic         tx_req_o,
    output logic [127:0] tx_dt_o,
    input  logic         tx_ack_i,
    output logic         busy_o,
    output logic [4:0]   fifo_cnt_o,
    output logic [15:0]  sent_cnt_o,
    output logic         timeout_o,
    input  logic         clr_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);
    localparam logic [15:0] TO_LIM = 16'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_NACK
    } state_t;

    state_t         state;
    logic [113:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [4:0]     cnt;
    logic [4:0]     seq;
    logic [15:0]    to_cnt;
    logic           ack_q;
    logic           ack_s;
    logic           push;
    logic           pop;
    logic [113:0]   head;

    assign in_ready_o = (cnt != FULL);
    assign push       = in_valid_i & in_ready_o;
    assign pop        = (state == IDLE) & (cnt != 5'd0) & ~ack_s;
    assign head       = mem[rd_ptr];
    assign fifo_cnt_o = cnt;
    assign busy_o     = (cnt != 5'd0) | (state != IDLE);

    // Entry layout: {op, sync, dst, payload}
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {in_op_i, in_sync_i, in_dst_i, in_dt_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= 5'd0;
            seq        <= 5'd0;
            to_cnt     <= 16'd0;
            ack_q      <= 1'b0;
            ack_s      <= 1'b0;
            tx_req_o   <= 1'b0;
            tx_dt_o    <= 128'd0;
            sent_cnt_o <= 16'd0;
            timeout_o  <= 1'b0;
        end else begin
            ack_q <= tx_ack_i;
            ack_s <= ack_q;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 5'd1;
                2'b01:   cnt <= cnt - 5'd1;
                default: cnt <= cnt;
            endcase
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_dt_o  <= {head[113:106], head[105], seq,
                                     head[104:96], 1'b0, ID, head[95:0]};
                        seq      <= seq + 5'd1;
                        to_cnt   <= 16'd0;
                        tx_req_o <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (to_cnt != 16'hFFFF) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                    if (to_cnt == TO_LIM) begin
                        timeout_o <= 1'b1;
                    end
                    if (ack_s) begin
                        tx_req_o <= 1'b0;
                        state    <= WAIT_NACK;
                    end
                end
                WAIT_NACK: begin
                    if (!ack_s) begin
                        sent_cnt_o <= sent_cnt_o + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A clear overrides any same-cycle completion or timeout
            if (clr_i) begin
                timeout_o  <= 1'b0;
                sent_cnt_o <= 16'd0;
            end
        end
    end

endmodule
